input_ram_loader: RTL and testbench

//  Writer side of the input operand RAM. Streams operand words from a valid/ready source into the input RAM.

---
 rtl/input_ram_loader.sv | 155 +++++++++++++++
 tb/tb_input_ram_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_ram_loader.sv
// Writer side of the input operand RAM: streams a batch of words into the RAM,
// zero-pads the remaining addresses, then runs the start/done handshake with the Controller.
module input_ram_loader #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int START_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              start,
    input  logic              done,
    output logic              busy,
    output logic [ADDR_W:0]   loaded_cnt,
    output logic              batch_done,
    output logic              err_overflow
);

    localparam int CNT_W = $clog2(START_CYCLES) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_PAD       = 3'd2,
        S_START     = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   loaded_cnt_r;
    logic [CNT_W-1:0]  start_cnt_r;
    logic              start_r;
    logic              batch_done_r;
    logic              err_overflow_r;

    logic              in_ready_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic              xfer_s;

    // Write port and source handshake decode; stream words go to the RAM in the cycle they are accepted.
    always_comb begin
        in_ready_s  = 1'b0;
        ram_we_s    = 1'b0;
        ram_wdata_s = {DATA_W{1'b0}};
        case (state_r)
            S_LOAD: begin
                in_ready_s = 1'b1;
                ram_we_s   = in_valid;
                if (in_valid) begin
                    ram_wdata_s = in_data;
                end else begin
                    ram_wdata_s = {DATA_W{1'b0}};
                end
            end
            S_PAD: begin
                ram_we_s    = 1'b1;
                ram_wdata_s = {DATA_W{1'b0}};
            end
            default: begin
                in_ready_s  = 1'b0;
                ram_we_s    = 1'b0;
                ram_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    assign xfer_s = in_valid & in_ready_s;

    // Batch sequencer: address/count bookkeeping, start pulse timing and done handling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= S_IDLE;
            addr_r         <= {ADDR_W{1'b0}};
            loaded_cnt_r   <= {(ADDR_W+1){1'b0}};
            start_cnt_r    <= {CNT_W{1'b0}};
            start_r        <= 1'b0;
            batch_done_r   <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            batch_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (load_req) begin
                        addr_r         <= {ADDR_W{1'b0}};
                        loaded_cnt_r   <= {(ADDR_W+1){1'b0}};
                        err_overflow_r <= 1'b0;
                        state_r        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (xfer_s) begin
                        addr_r       <= addr_r + ADDR_W'(1);
                        loaded_cnt_r <= loaded_cnt_r + (ADDR_W+1)'(1);
                        if (addr_r == LAST_ADDR) begin
                            // RAM is full: a missing in_last here means the source overran the batch
                            err_overflow_r <= ~in_last;
                            start_r        <= 1'b1;
                            start_cnt_r    <= CNT_W'(START_CYCLES - 1);
                            state_r        <= S_START;
                        end else if (in_last) begin
                            state_r <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    addr_r <= addr_r + ADDR_W'(1);
                    if (addr_r == LAST_ADDR) begin
                        start_r     <= 1'b1;
                        start_cnt_r <= CNT_W'(START_CYCLES - 1);
                        state_r     <= S_START;
                    end
                end
                S_START: begin
                    if (start_cnt_r == CNT_W'(0)) begin
                        start_r <= 1'b0;
                        state_r <= S_WAIT_DONE;
                    end else begin
                        start_cnt_r <= start_cnt_r - CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        batch_done_r <= 1'b1;
                        state_r      <= S_IDLE;
                    end
                end
                default: begin
                    start_r <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_s;
    assign ram_we       = ram_we_s;
    assign ram_addr     = addr_r;
    assign ram_wdata    = ram_wdata_s;
    assign start        = start_r;
    assign busy         = (state_r != S_IDLE);
    assign loaded_cnt   = loaded_cnt_r;
    assign batch_done   = batch_done_r;
    assign err_overflow = err_overflow_r;

endmodule

// File: tb/tb_input_ram_loader.sv
// Bench for input_ram_loader: directed and randomized batches checked against an
// expected RAM image built from the stream words, plus handshake and reset checks.
module tb_input_ram_loader;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 4;
    localparam int START_CYCLES = 2;
    localparam int DEPTH        = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_req;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              start;
    logic              done;
    logic              busy;
    logic [ADDR_W:0]   loaded_cnt;
    logic              batch_done;
    logic              err_overflow;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] tb_mem [DEPTH];
    logic [DATA_W-1:0] words [$];
    int                wr_log [$];
    int                cyc = 0;
    int                acc_cnt, start_hi, first_start_cyc, last_xfer_cyc, bd_pulses;

    always #5 clk = ~clk;

    input_ram_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .START_CYCLES(START_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_req(load_req),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .start(start),
        .done(done),
        .busy(busy),
        .loaded_cnt(loaded_cnt),
        .batch_done(batch_done),
        .err_overflow(err_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe settled outputs at the falling edge, then return 1 time unit after the rising edge.
    task automatic tick(output bit xf);
        @(negedge clk);
        xf = (in_valid === 1'b1) && (in_ready === 1'b1);
        if (ram_we === 1'b1 && !$isunknown(ram_addr)) begin
            tb_mem[ram_addr] = ram_wdata;
            wr_log.push_back(int'(ram_addr));
        end
        if (xf) begin
            acc_cnt++;
            last_xfer_cyc = cyc;
        end
        if (start === 1'b1) begin
            if (start_hi == 0) first_start_cyc = cyc;
            start_hi++;
        end
        if (batch_done === 1'b1) bd_pulses++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_batch(input string name, input int n, input bit has_last, input int mode);
        int n_acc, idx, budget, bad, waits;
        bit exp_err, xf, vbit;
        logic [DATA_W-1:0] exp_word;
        n_acc   = (has_last && n <= DEPTH) ? n : DEPTH;
        exp_err = !(has_last && n <= DEPTH);
        wr_log.delete();
        acc_cnt = 0; start_hi = 0; bd_pulses = 0; first_start_cyc = -1; last_xfer_cyc = -1;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 16'hDEAD;

        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        check({name, "_idle_ready"}, 32'(in_ready), 32'd0);
        load_req = 1'b1;
        tick(xf);
        load_req = 1'b0;
        check({name, "_ready_latency"}, 32'(in_ready), 32'd1);
        check({name, "_err_cleared"}, 32'(err_overflow), 32'd0);
        check({name, "_cnt_cleared"}, 32'(loaded_cnt), 32'd0);

        idx = 0;
        budget = 0;
        while (start !== 1'b1 && budget < 300) begin
            case (mode)
                0:       vbit = 1'b1;
                1:       vbit = (budget % 3 == 0);
                default: vbit = ($urandom_range(0, 2) != 0);
            endcase
            // after the stream ends keep offering junk; nothing more may be consumed
            in_valid = (idx < n) ? vbit : 1'b1;
            in_data  = (idx < n) ? words[idx] : 16'hBAD0;
            in_last  = has_last && (idx == n - 1);
            load_req = ($urandom_range(0, 7) == 0);
            done     = ($urandom_range(0, 7) == 0);
            tick(xf);
            if (xf) idx++;
            budget++;
        end
        check({name, "_start_seen"}, 32'(start), 32'd1);
        in_valid = 1'b0; in_last = 1'b0; load_req = 1'b0;

        done = 1'b1;
        tick(xf);
        done = 1'b0;
        budget = 0;
        while (start === 1'b1 && budget < 20) begin
            tick(xf);
            budget++;
        end
        check({name, "_start_width"}, 32'(start_hi), 32'(START_CYCLES));
        check({name, "_busy_wait"}, 32'(busy), 32'd1);
        check({name, "_no_early_bd"}, 32'(bd_pulses), 32'd0);

        waits = $urandom_range(0, 3);
        for (int w = 0; w < waits; w++) begin
            load_req = ($urandom_range(0, 1) == 1);
            tick(xf);
        end
        load_req = 1'b0;
        done = 1'b1;
        tick(xf);
        done = 1'b0;
        check({name, "_batch_done"}, 32'(batch_done), 32'd1);
        check({name, "_idle_after"}, 32'(busy), 32'd0);
        tick(xf);
        check({name, "_bd_pulse"}, 32'(bd_pulses), 32'd1);
        check({name, "_bd_low"}, 32'(batch_done), 32'd0);

        check({name, "_accepted"}, 32'(acc_cnt), 32'(n_acc));
        check({name, "_loaded_cnt"}, 32'(loaded_cnt), 32'(n_acc));
        check({name, "_err_overflow"}, 32'(err_overflow), 32'(exp_err));
        check({name, "_write_count"}, 32'(wr_log.size()), 32'(DEPTH));
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != i) bad++;
        check({name, "_addr_seq"}, 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_word = (i < n_acc) ? words[i] : 16'h0000;
            if (tb_mem[i] !== exp_word) bad++;
        end
        check({name, "_ram_image"}, 32'(bad), 32'd0);
        check({name, "_start_latency"}, 32'(first_start_cyc - last_xfer_cyc), 32'(DEPTH - n_acc + 1));
    endtask

    initial begin
        bit xf;
        int n;
        rst = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0; done = 1'b0;
        #1;
        check("reset_start", 32'(start), 32'd0);
        check("reset_we", 32'(ram_we), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cnt", 32'(loaded_cnt), 32'd0);
        check("reset_err", 32'(err_overflow), 32'd0);
        check("reset_bd", 32'(batch_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        words.delete();
        for (int i = 0; i < 16; i++) words.push_back(16'((i + 1) * 16'h0101));
        run_batch("t1_full", 16, 1'b1, 0);

        words.delete();
        words.push_back(16'hABCD); words.push_back(16'h1234); words.push_back(16'hFFFF);
        run_batch("t2_short", 3, 1'b1, 0);

        words.delete();
        for (int i = 0; i < 20; i++) words.push_back(16'($urandom));
        run_batch("t3_overflow", 20, 1'b0, 0);

        words.delete();
        for (int i = 0; i < 10; i++) words.push_back(16'($urandom));
        run_batch("t4_backpressure", 10, 1'b1, 1);

        words.delete();
        words.push_back(16'($urandom));
        run_batch("t5_single", 1, 1'b1, 2);

        for (int b = 0; b < 6; b++) begin
            words.delete();
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 22) : $urandom_range(1, 16);
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            run_batch($sformatf("rnd%0d", b), n, (n <= DEPTH), 2);
        end

        // reset in the middle of LOAD with seven words already written
        load_req = 1'b1;
        tick(xf);
        load_req = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 16'(16'h7000 + i);
            tick(xf);
        end
        check("t6_pre_addr", 32'(ram_addr), 32'd7);
        check("t6_pre_we", 32'(ram_we), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_async_we", 32'(ram_we), 32'd0);
        check("t6_async_ready", 32'(in_ready), 32'd0);
        check("t6_async_start", 32'(start), 32'd0);
        check("t6_async_cnt", 32'(loaded_cnt), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_idle", 32'(busy), 32'd0);
        check("t6_cnt", 32'(loaded_cnt), 32'd0);

        // reset while start is high drops it at once
        load_req = 1'b1;
        tick(xf);
        load_req = 1'b0;
        in_valid = 1'b1; in_last = 1'b1; in_data = 16'h5555;
        tick(xf);
        in_valid = 1'b0; in_last = 1'b0;
        n = 0;
        while (start !== 1'b1 && n < 40) begin
            tick(xf);
            n++;
        end
        check("t6b_start_high", 32'(start), 32'd1);
        rst = 1'b0;
        #1;
        check("t6b_async_start", 32'(start), 32'd0);
        check("t6b_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
